// File: rtl/servo_pwm_driver.sv
// Dual 50 Hz wheel-servo pulse generator with per-frame slew limiting on the pulse widths.
// Define SERVO_WATCHDOG_EN to recentre the targets after WD_FRAMES frames without cmd_valid.
module servo_pwm_driver #(
  parameter int WIDTH_CMD = 4,
  parameter int PERIOD_US = 20000,
  parameter int CENTER_US = 1500,
  parameter int STEP_US   = 60,
  parameter int SLEW_US   = 40,
  parameter int MIN_US    = 1000,
  parameter int MAX_US    = 2000,
  parameter int WD_FRAMES = 25
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 one_MHz_enable,
  input  logic [WIDTH_CMD-1:0] cmd_left,
  input  logic [WIDTH_CMD-1:0] cmd_right,
  input  logic                 cmd_valid,
  output logic                 pwm_left,
  output logic                 pwm_right,
  output logic                 frame_start,
  output logic [10:0]          width_left,
  output logic [10:0]          width_right
);

  localparam int unsigned CNT_W   = $clog2(PERIOD_US);
  localparam int unsigned WID_W   = 11;
  localparam int unsigned ARITH_W = 16;

  typedef logic signed [ARITH_W-1:0] arith_t;

  logic signed [WIDTH_CMD-1:0] cmd_l_q, cmd_l_d, cmd_r_q, cmd_r_d;
  logic [CNT_W-1:0]            us_count_q, us_count_d;
  logic [WID_W-1:0]            width_l_q, width_l_d, width_r_q, width_r_d;
  logic                        pwm_l_q, pwm_l_d, pwm_r_q, pwm_r_d;
  logic                        frame_start_q, frame_start_d;
  logic                        boundary_c;
  logic                        force_center_c;
  arith_t                      tgt_l_c, tgt_r_c;

  function automatic arith_t clamp_us(arith_t v);
    if (v < arith_t'(MIN_US)) return arith_t'(MIN_US);
    if (v > arith_t'(MAX_US)) return arith_t'(MAX_US);
    return v;
  endfunction

  // Move at most SLEW_US toward the target; snap when within reach.
  function automatic logic [WID_W-1:0] slew_us(logic [WID_W-1:0] w, arith_t t);
    arith_t cur;
    arith_t diff;
    cur  = arith_t'(w);
    diff = t - cur;
    if (diff > arith_t'(SLEW_US))  return WID_W'(cur + arith_t'(SLEW_US));
    if (diff < -arith_t'(SLEW_US)) return WID_W'(cur - arith_t'(SLEW_US));
    return WID_W'(t);
  endfunction

  assign boundary_c = one_MHz_enable && (us_count_q == CNT_W'(PERIOD_US - 1));

`ifdef SERVO_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WD_FRAMES + 1);

  logic [WD_W-1:0] wd_q, wd_d;

  always_comb begin
    wd_d = wd_q;
    if (cmd_valid) begin
      wd_d = '0;
    end else if (boundary_c && (wd_q != WD_W'(WD_FRAMES))) begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wd_q <= '0;
    else       wd_q <= wd_d;
  end

  assign force_center_c = (wd_q == WD_W'(WD_FRAMES));
`else
  logic unused_cmd_valid;
  localparam int unused_wd_frames = WD_FRAMES;
  assign unused_cmd_valid = cmd_valid;
  assign force_center_c   = 1'b0;
`endif

  // Right servo is mounted mirrored, so its command is subtracted.
  always_comb begin
    tgt_l_c = arith_t'(CENTER_US);
    tgt_r_c = arith_t'(CENTER_US);
    if (!force_center_c) begin
      tgt_l_c = clamp_us(arith_t'(CENTER_US) + arith_t'(cmd_l_q) * arith_t'(STEP_US));
      tgt_r_c = clamp_us(arith_t'(CENTER_US) - arith_t'(cmd_r_q) * arith_t'(STEP_US));
    end
  end

  always_comb begin
    cmd_l_d       = cmd_left;
    cmd_r_d       = cmd_right;
    us_count_d    = us_count_q;
    width_l_d     = width_l_q;
    width_r_d     = width_r_q;
    frame_start_d = boundary_c;
    pwm_l_d       = enable && (32'(us_count_q) < 32'(width_l_q));
    pwm_r_d       = enable && (32'(us_count_q) < 32'(width_r_q));
    if (one_MHz_enable) begin
      us_count_d = boundary_c ? '0 : us_count_q + CNT_W'(1);
    end
    if (!enable) begin
      width_l_d = WID_W'(CENTER_US);
      width_r_d = WID_W'(CENTER_US);
    end else if (boundary_c) begin
      width_l_d = slew_us(width_l_q, tgt_l_c);
      width_r_d = slew_us(width_r_q, tgt_r_c);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_l_q       <= '0;
      cmd_r_q       <= '0;
      us_count_q    <= '0;
      width_l_q     <= WID_W'(CENTER_US);
      width_r_q     <= WID_W'(CENTER_US);
      pwm_l_q       <= 1'b0;
      pwm_r_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      cmd_l_q       <= cmd_l_d;
      cmd_r_q       <= cmd_r_d;
      us_count_q    <= us_count_d;
      width_l_q     <= width_l_d;
      width_r_q     <= width_r_d;
      pwm_l_q       <= pwm_l_d;
      pwm_r_q       <= pwm_r_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pwm_left    = pwm_l_q;
  assign pwm_right   = pwm_r_q;
  assign frame_start = frame_start_q;
  assign width_left  = width_l_q;
  assign width_right = width_r_q;

endmodule

// File: tb/tb_servo_pwm_driver.sv
// Bench for servo_pwm_driver: two instances (STEP 60 and STEP 200) on a shortened frame,
// checked against a frame-level reference model plus a table of hand-derived widths.
module tb_servo_pwm_driver;

  localparam int P  = 2100;
  localparam int C  = 1500;
  localparam int SL = 40;
  localparam int MN = 1000;
  localparam int MX = 2000;
  localparam int STEPS [2] = '{60, 200};

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b1;
  logic              tick = 1'b0;
  logic              cmd_valid = 1'b0;
  logic signed [3:0] cmd_l = '0;
  logic signed [3:0] cmd_r = '0;
  logic              pwm_l [2];
  logic              pwm_r [2];
  logic              fs [2];
  logic [10:0]       wid_l [2];
  logic [10:0]       wid_r [2];

  int  checks = 0;
  int  failures = 0;
  bit  tick_full = 1'b0;

  always #20 clk = ~clk;

  servo_pwm_driver #(.PERIOD_US(P), .STEP_US(60)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .one_MHz_enable(tick),
    .cmd_left(cmd_l), .cmd_right(cmd_r), .cmd_valid(cmd_valid),
    .pwm_left(pwm_l[0]), .pwm_right(pwm_r[0]), .frame_start(fs[0]),
    .width_left(wid_l[0]), .width_right(wid_r[0]));

  servo_pwm_driver #(.PERIOD_US(P), .STEP_US(200)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .one_MHz_enable(tick),
    .cmd_left(cmd_l), .cmd_right(cmd_r), .cmd_valid(cmd_valid),
    .pwm_left(pwm_l[1]), .pwm_right(pwm_r[1]), .frame_start(fs[1]),
    .width_left(wid_l[1]), .width_right(wid_r[1]));

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: microsecond time, target = clamped linear map, bounded step per frame.
  int m_us;
  int m_wl [2];
  int m_wr [2];
  int m_cl, m_cr;
  bit m_pl [2];
  bit m_pr [2];
  bit m_fs;

  function automatic int target(int cmd, int step, bit mirrored);
    int t;
    t = mirrored ? C - cmd * step : C + cmd * step;
    if (t < MN) t = MN;
    if (t > MX) t = MX;
    return t;
  endfunction

  function automatic int approach(int w, int t);
    if (t - w > SL) return w + SL;
    if (w - t > SL) return w - SL;
    return t;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_us = 0; m_cl = 0; m_cr = 0; m_fs = 0;
      for (int i = 0; i < 2; i++) begin
        m_wl[i] = C; m_wr[i] = C; m_pl[i] = 0; m_pr[i] = 0;
      end
    end else begin
      m_fs = tick && (m_us == P - 1);
      for (int i = 0; i < 2; i++) begin
        m_pl[i] = enable && (m_us < m_wl[i]);
        m_pr[i] = enable && (m_us < m_wr[i]);
        if (!enable) begin
          m_wl[i] = C; m_wr[i] = C;
        end else if (m_fs) begin
          m_wl[i] = approach(m_wl[i], target(m_cl, STEPS[i], 1'b0));
          m_wr[i] = approach(m_wr[i], target(m_cr, STEPS[i], 1'b1));
        end
      end
      m_cl = int'(cmd_l);
      m_cr = int'(cmd_r);
      if (tick) m_us = (m_us + 1) % P;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("model_pwm_left[%0d]", i), int'(pwm_l[i]), int'(m_pl[i]));
        chk($sformatf("model_pwm_right[%0d]", i), int'(pwm_r[i]), int'(m_pr[i]));
        chk($sformatf("model_frame_start[%0d]", i), int'(fs[i]), int'(m_fs));
        chk($sformatf("model_width_left[%0d]", i), int'(wid_l[i]), m_wl[i]);
        chk($sformatf("model_width_right[%0d]", i), int'(wid_r[i]), m_wr[i]);
      end
    end
  end

  always @(negedge clk) tick = tick_full ? 1'b1 : ($urandom_range(3) != 0);

  task automatic wait_frames(int n);
    for (int k = 0; k < n; k++) begin
      int cyc;
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!fs[0] && cyc < 20000);
      if (!fs[0]) chk("frame_timeout", int'(fs[0]), 1);
    end
  endtask

  // Count high cycles of each dut0 pulse across one full frame (tick every clock).
  task automatic measure(output int len_l, output int len_r, input int chg_at,
                         input logic signed [3:0] new_l, input logic signed [3:0] new_r);
    int cyc;
    cyc = 0; len_l = 0; len_r = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (pwm_l[0]) len_l++;
      if (pwm_r[0]) len_r++;
      if (cyc == chg_at) begin
        cmd_l = new_l;
        cmd_r = new_r;
      end
    end while (!fs[0] && cyc < 20000);
    if (!fs[0]) chk("measure_timeout", int'(fs[0]), 1);
  endtask

  typedef struct {
    logic signed [3:0] cl;
    logic signed [3:0] cr;
    int frames;
    int wl0, wr0, wl1, wr1;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int ll, lr;
    vecs[0] = '{cl:  0, cr:  0, frames: 1, wl0: 1500, wr0: 1500, wl1: 1500, wr1: 1500};
    vecs[1] = '{cl:  5, cr:  5, frames: 1, wl0: 1540, wr0: 1460, wl1: 1540, wr1: 1460};
    vecs[2] = '{cl:  5, cr:  5, frames: 5, wl0: 1740, wr0: 1260, wl1: 1740, wr1: 1260};
    vecs[3] = '{cl:  5, cr:  5, frames: 2, wl0: 1800, wr0: 1200, wl1: 1820, wr1: 1180};
    vecs[4] = '{cl:  7, cr: -8, frames: 5, wl0: 1920, wr0: 1400, wl1: 2000, wr1: 1380};
    vecs[5] = '{cl: -8, cr:  7, frames: 1, wl0: 1880, wr0: 1360, wl1: 1960, wr1: 1340};

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_pwm_left[%0d]", i), int'(pwm_l[i]), 0);
      chk($sformatf("reset_pwm_right[%0d]", i), int'(pwm_r[i]), 0);
      chk($sformatf("reset_frame_start[%0d]", i), int'(fs[i]), 0);
      chk($sformatf("reset_width_left[%0d]", i), int'(wid_l[i]), C);
    end
    reset = 1'b0;

    tick_full = 1'b1;
    wait_frames(1);
    measure(ll, lr, 0, 4'sd0, 4'sd0);
    chk("pulse_len_left_center", ll, 1500);
    chk("pulse_len_right_center", lr, 1500);
    tick_full = 1'b0;

    for (int v = 0; v < 6; v++) begin
      cmd_l = vecs[v].cl;
      cmd_r = vecs[v].cr;
      wait_frames(vecs[v].frames);
      chk($sformatf("vec%0d_width_left0", v), int'(wid_l[0]), vecs[v].wl0);
      chk($sformatf("vec%0d_width_right0", v), int'(wid_r[0]), vecs[v].wr0);
      chk($sformatf("vec%0d_width_left1", v), int'(wid_l[1]), vecs[v].wl1);
      chk($sformatf("vec%0d_width_right1", v), int'(wid_r[1]), vecs[v].wr1);
    end

    // Mid-frame command change must not disturb the pulse in flight.
    tick_full = 1'b1;
    wait_frames(1);
    chk("midframe_start_width_left", int'(wid_l[0]), 1840);
    measure(ll, lr, 700, 4'sd0, 4'sd0);
    chk("midframe_pulse_left", ll, 1840);
    chk("midframe_pulse_right", lr, 1320);
    chk("midframe_next_width_left", int'(wid_l[0]), 1800);
    chk("midframe_next_width_right", int'(wid_r[0]), 1360);

    // Drop enable mid-pulse, then re-enable and slew from centre.
    repeat (50) @(negedge clk);
    chk("pre_disable_pwm_left", int'(pwm_l[0]), 1);
    enable = 1'b0;
    @(negedge clk);
    chk("disable_pwm_left", int'(pwm_l[0]), 0);
    chk("disable_pwm_right", int'(pwm_r[0]), 0);
    chk("disable_width_left", int'(wid_l[0]), C);
    chk("disable_width_right", int'(wid_r[0]), C);
    enable = 1'b1;
    cmd_l = 4'sd5;
    cmd_r = 4'sd0;
    wait_frames(1);
    chk("reenable_width_left", int'(wid_l[0]), 1540);
    chk("reenable_width_right", int'(wid_r[0]), 1500);

    // Random commands, strobe gaps, enable glitches and cmd_valid noise.
    tick_full = 1'b0;
    for (int c = 0; c < 15000; c++) begin
      @(negedge clk);
      if ($urandom_range(299) == 0) begin
        cmd_l = 4'($urandom);
        cmd_r = 4'($urandom);
      end
      if ($urandom_range(1999) == 0) enable = 1'b0;
      else if ($urandom_range(99) == 0) enable = 1'b1;
      cmd_valid = ($urandom_range(49) == 0);
    end
    enable = 1'b1;

    // Reset mid-frame: outputs fall immediately.
    repeat (333) @(negedge clk);
    #5 reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("midreset_pwm_left[%0d]", i), int'(pwm_l[i]), 0);
      chk($sformatf("midreset_pwm_right[%0d]", i), int'(pwm_r[i]), 0);
      chk($sformatf("midreset_frame_start[%0d]", i), int'(fs[i]), 0);
      chk($sformatf("midreset_width_right[%0d]", i), int'(wid_r[i]), C);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3000) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
